// File: rtl/fold_deserializer_three.sv
// Reassembles three consecutive fold-step words into one parallel frame,
// using the first-word marker to check and recover fold-phase alignment.
module fold_deserializer_three #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_first,
  input  logic [WIDTH-1:0] in,
  output logic             out_valid,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic             align_err,
  output logic [1:0]       phase
);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_phase;
  logic [1:0]       w_phase_nxt;
  logic [WIDTH-1:0] r_s0;
  logic [WIDTH-1:0] w_s0_nxt;
  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] w_s1_nxt;
  logic [WIDTH-1:0] r_out0;
  logic [WIDTH-1:0] w_out0_nxt;
  logic [WIDTH-1:0] r_out1;
  logic [WIDTH-1:0] w_out1_nxt;
  logic [WIDTH-1:0] r_out2;
  logic [WIDTH-1:0] w_out2_nxt;
  logic             r_out_valid;
  logic             w_out_valid_nxt;
  logic             r_align_err;
  logic             w_align_err_nxt;

  // State, staging and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_phase     <= 2'd0;
      r_s0        <= {WIDTH{1'b0}};
      r_s1        <= {WIDTH{1'b0}};
      r_out0      <= {WIDTH{1'b0}};
      r_out1      <= {WIDTH{1'b0}};
      r_out2      <= {WIDTH{1'b0}};
      r_out_valid <= 1'b0;
      r_align_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_phase     <= w_phase_nxt;
      r_s0        <= w_s0_nxt;
      r_s1        <= w_s1_nxt;
      r_out0      <= w_out0_nxt;
      r_out1      <= w_out1_nxt;
      r_out2      <= w_out2_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_align_err <= w_align_err_nxt;
    end
  end

  // Next-state logic; strobes default low, everything else holds
  always_comb begin
    w_state_nxt     = r_state;
    w_phase_nxt     = r_phase;
    w_s0_nxt        = r_s0;
    w_s1_nxt        = r_s1;
    w_out0_nxt      = r_out0;
    w_out1_nxt      = r_out1;
    w_out2_nxt      = r_out2;
    w_out_valid_nxt = 1'b0;
    w_align_err_nxt = 1'b0;

    if (in_valid) begin
      case (r_state)
        IDLE: begin
          if (in_first) begin
            w_s0_nxt    = in;
            w_phase_nxt = 2'd1;
            w_state_nxt = COLLECT;
          end else begin
            w_phase_nxt = 2'd0;
          end
        end
        COLLECT: begin
          if (in_first) begin
            // A marker away from phase 0 abandons the partial frame and resyncs
            w_align_err_nxt = (r_phase != 2'd0) ? 1'b1 : 1'b0;
            w_s0_nxt        = in;
            w_phase_nxt     = 2'd1;
          end else begin
            case (r_phase)
              2'd1: begin
                w_s1_nxt    = in;
                w_phase_nxt = 2'd2;
              end
              2'd2: begin
                w_out0_nxt      = r_s0;
                w_out1_nxt      = r_s1;
                w_out2_nxt      = in;
                w_out_valid_nxt = 1'b1;
                w_phase_nxt     = 2'd0;
              end
              default: begin
                w_align_err_nxt = 1'b1;
                w_phase_nxt     = 2'd0;
                w_state_nxt     = IDLE;
              end
            endcase
          end
        end
        default: begin
          w_phase_nxt = 2'd0;
          w_state_nxt = IDLE;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  assign out_valid = r_out_valid;
  assign out0      = r_out0;
  assign out1      = r_out1;
  assign out2      = r_out2;
  assign align_err = r_align_err;
  assign phase     = r_phase;

endmodule

// File: tb/tb_fold_deserializer_three.sv
// Directed table-driven bench for fold_deserializer_three plus hand-written
// reset and startup-hunting sequences.
module tb_fold_deserializer_three;

  localparam int WIDTH = 20;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_first;
  logic [WIDTH-1:0] in_w;
  logic             out_valid;
  logic [WIDTH-1:0] out0;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;
  logic             align_err;
  logic [1:0]       phase;

  int n_tests;
  int n_fail;
  int n_ov;
  int n_err;

  typedef struct {
    logic             v;
    logic             f;
    logic [WIDTH-1:0] d;
    logic             ov;
    logic             er;
    logic [1:0]       ph;
    logic [WIDTH-1:0] o0;
    logic [WIDTH-1:0] o1;
    logic [WIDTH-1:0] o2;
  } vec_t;

  vec_t tbl[$];

  fold_deserializer_three #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .in        (in_w),
    .out_valid (out_valid),
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .align_err (align_err),
    .phase     (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic v, logic f, logic [WIDTH-1:0] d, logic ov, logic er,
                              logic [1:0] ph, logic [WIDTH-1:0] o0, logic [WIDTH-1:0] o1,
                              logic [WIDTH-1:0] o2);
    vec_t t;
    t.v = v; t.f = f; t.d = d; t.ov = ov; t.er = er; t.ph = ph;
    t.o0 = o0; t.o1 = o1; t.o2 = o2;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, let the rising edge capture, sample 1 time unit later
  task automatic step(input logic v, input logic f, input logic [WIDTH-1:0] d);
    @(negedge clk);
    in_valid = v;
    in_first = f;
    in_w     = d;
    @(posedge clk);
    #1;
    if (out_valid === 1'b1) n_ov++;
    if (align_err === 1'b1) n_err++;
  endtask

  task automatic chk_all(input string tag, input vec_t t);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, t.ov});
    chk({tag, ".align_err"}, {31'd0, align_err}, {31'd0, t.er});
    chk({tag, ".phase"},     {30'd0, phase},     {30'd0, t.ph});
    chk({tag, ".out0"},      {12'd0, out0},      {12'd0, t.o0});
    chk({tag, ".out1"},      {12'd0, out1},      {12'd0, t.o1});
    chk({tag, ".out2"},      {12'd0, out2},      {12'd0, t.o2});
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    n_ov     = 0;
    n_err    = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_w     = 20'h00000;

    // Gap-free frames
    tbl.push_back(mk(1'b1, 1'b1, 20'h00001, 1'b0, 1'b0, 2'd1, 20'h0, 20'h0, 20'h0));
    tbl.push_back(mk(1'b1, 1'b0, 20'h00002, 1'b0, 1'b0, 2'd2, 20'h0, 20'h0, 20'h0));
    tbl.push_back(mk(1'b1, 1'b0, 20'h00003, 1'b1, 1'b0, 2'd0, 20'h1, 20'h2, 20'h3));
    tbl.push_back(mk(1'b1, 1'b1, 20'h00004, 1'b0, 1'b0, 2'd1, 20'h1, 20'h2, 20'h3));
    tbl.push_back(mk(1'b1, 1'b0, 20'h00005, 1'b0, 1'b0, 2'd2, 20'h1, 20'h2, 20'h3));
    tbl.push_back(mk(1'b1, 1'b0, 20'h00006, 1'b1, 1'b0, 2'd0, 20'h4, 20'h5, 20'h6));
    // Two-cycle gaps between words
    tbl.push_back(mk(1'b1, 1'b1, 20'h00001, 1'b0, 1'b0, 2'd1, 20'h4, 20'h5, 20'h6));
    tbl.push_back(mk(1'b0, 1'b0, 20'h0DEAD, 1'b0, 1'b0, 2'd1, 20'h4, 20'h5, 20'h6));
    tbl.push_back(mk(1'b0, 1'b1, 20'h0BEEF, 1'b0, 1'b0, 2'd1, 20'h4, 20'h5, 20'h6));
    tbl.push_back(mk(1'b1, 1'b0, 20'h00002, 1'b0, 1'b0, 2'd2, 20'h4, 20'h5, 20'h6));
    tbl.push_back(mk(1'b0, 1'b1, 20'h0DEAD, 1'b0, 1'b0, 2'd2, 20'h4, 20'h5, 20'h6));
    tbl.push_back(mk(1'b0, 1'b0, 20'h0BEEF, 1'b0, 1'b0, 2'd2, 20'h4, 20'h5, 20'h6));
    tbl.push_back(mk(1'b1, 1'b0, 20'h00003, 1'b1, 1'b0, 2'd0, 20'h1, 20'h2, 20'h3));
    tbl.push_back(mk(1'b0, 1'b0, 20'h00000, 1'b0, 1'b0, 2'd0, 20'h1, 20'h2, 20'h3));
    // Early marker at phase 2, then at phase 1
    tbl.push_back(mk(1'b1, 1'b1, 20'hAAAAA, 1'b0, 1'b0, 2'd1, 20'h1, 20'h2, 20'h3));
    tbl.push_back(mk(1'b1, 1'b0, 20'hBBBBB, 1'b0, 1'b0, 2'd2, 20'h1, 20'h2, 20'h3));
    tbl.push_back(mk(1'b1, 1'b1, 20'hCCCCC, 1'b0, 1'b1, 2'd1, 20'h1, 20'h2, 20'h3));
    tbl.push_back(mk(1'b1, 1'b0, 20'hDDDDD, 1'b0, 1'b0, 2'd2, 20'h1, 20'h2, 20'h3));
    tbl.push_back(mk(1'b1, 1'b0, 20'hEEEEE, 1'b1, 1'b0, 2'd0, 20'hCCCCC, 20'hDDDDD, 20'hEEEEE));
    tbl.push_back(mk(1'b1, 1'b1, 20'h12121, 1'b0, 1'b0, 2'd1, 20'hCCCCC, 20'hDDDDD, 20'hEEEEE));
    tbl.push_back(mk(1'b1, 1'b1, 20'h34343, 1'b0, 1'b1, 2'd1, 20'hCCCCC, 20'hDDDDD, 20'hEEEEE));
    tbl.push_back(mk(1'b0, 1'b0, 20'h00000, 1'b0, 1'b0, 2'd1, 20'hCCCCC, 20'hDDDDD, 20'hEEEEE));
    tbl.push_back(mk(1'b1, 1'b0, 20'h56565, 1'b0, 1'b0, 2'd2, 20'hCCCCC, 20'hDDDDD, 20'hEEEEE));
    tbl.push_back(mk(1'b1, 1'b0, 20'h78787, 1'b1, 1'b0, 2'd0, 20'h34343, 20'h56565, 20'h78787));
    // Missing marker after a completed frame, then IDLE drop and recovery
    tbl.push_back(mk(1'b1, 1'b0, 20'h11111, 1'b0, 1'b1, 2'd0, 20'h34343, 20'h56565, 20'h78787));
    tbl.push_back(mk(1'b1, 1'b0, 20'h22222, 1'b0, 1'b0, 2'd0, 20'h34343, 20'h56565, 20'h78787));
    tbl.push_back(mk(1'b0, 1'b1, 20'h99999, 1'b0, 1'b0, 2'd0, 20'h34343, 20'h56565, 20'h78787));
    tbl.push_back(mk(1'b1, 1'b1, 20'h33333, 1'b0, 1'b0, 2'd1, 20'h34343, 20'h56565, 20'h78787));
    tbl.push_back(mk(1'b1, 1'b0, 20'h44444, 1'b0, 1'b0, 2'd2, 20'h34343, 20'h56565, 20'h78787));
    tbl.push_back(mk(1'b1, 1'b0, 20'h55555, 1'b1, 1'b0, 2'd0, 20'h33333, 20'h44444, 20'h55555));

    repeat (2) @(posedge clk);
    #1;
    chk_all("reset0", mk(1'b0, 1'b0, 20'h0, 1'b0, 1'b0, 2'd0, 20'h0, 20'h0, 20'h0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].f, tbl[i].d);
      chk_all($sformatf("vec%0d", i), tbl[i]);
    end

    // Startup hunting: two unmarked words after reset, then a valid triple
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    n_ov  = 0;
    n_err = 0;
    step(1'b1, 1'b0, 20'hFFFFF);
    step(1'b1, 1'b0, 20'hFFFFE);
    chk("hunt.phase", {30'd0, phase}, 32'd0);
    step(1'b1, 1'b1, 20'h12345);
    step(1'b1, 1'b0, 20'h0ABCD);
    step(1'b1, 1'b0, 20'h54321);
    chk_all("hunt", mk(1'b0, 1'b0, 20'h0, 1'b1, 1'b0, 2'd0, 20'h12345, 20'h0ABCD, 20'h54321));
    step(1'b0, 1'b0, 20'h00000);
    chk("hunt.n_ov", n_ov, 32'd1);
    chk("hunt.n_err", n_err, 32'd0);

    // Asynchronous reset mid-frame with out0=0x12345 loaded
    step(1'b1, 1'b1, 20'h77777);
    chk("mid.phase_pre", {30'd0, phase}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", mk(1'b0, 1'b0, 20'h0, 1'b0, 1'b0, 2'd0, 20'h0, 20'h0, 20'h0));
    @(negedge clk);
    rst   = 1'b0;
    n_ov  = 0;
    n_err = 0;
    // Partial frame must be gone: unmarked words are dropped in IDLE
    step(1'b1, 1'b0, 20'h66666);
    step(1'b1, 1'b0, 20'h67676);
    step(1'b0, 1'b0, 20'h00000);
    chk_all("post_rst", mk(1'b0, 1'b0, 20'h0, 1'b0, 1'b0, 2'd0, 20'h0, 20'h0, 20'h0));
    chk("post_rst.n_ov", n_ov, 32'd0);
    chk("post_rst.n_err", n_err, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
